// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit.
//   - operation select encoding (OP_AND .. OP_XNOR; codes 6 and 7 are illegal)
//   - FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   - chunk_divides(): elaboration-time legality check for CHUNK vs WIDTH
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when the operand width splits into a whole number of chunks.
  function automatic bit chunk_divides(input int width, input int chunk);
    return (width > 0) && (chunk > 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit logic evaluator.
// Ports:
//   op  in  3      operation select (see logic_unit_pkg)
//   a   in  CHUNK  operand A slice
//   b   in  CHUNK  operand B slice
//   y   out CHUNK  op(a, b); all zeros for the illegal codes 6 and 7
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [2:0]       op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  // Pure bitwise select; illegal codes deliberately yield zero so the
  // completed result reads as 0 with the zero flag set.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates one CHUNK-bit slice per cycle,
// lowest slice first, under a start/done handshake, and produces a zero flag.
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request, accepted only when idle
//   op        in   3      operation select, captured on accept
//   a, b      in   WIDTH  operands, captured on accept
//   subtract  in   1      ALU-interface compatibility only; unused
//   busy      out  1      high while an operation is in flight
//   done      out  1      one-cycle pulse; result and zero are final
//   result    out  WIDTH  registered result, held until the next accept
//   zero      out  1      completed result is all zeros
//   carryout  out  1      constant 0
//   overflow  out  1      constant 0
module seq_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow
);

  localparam int NUM_SLICES = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  generate
    if (!chunk_divides(WIDTH, CHUNK)) begin : g_bad_chunk
      $fatal(1, "seq_logic_unit: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end
  endgenerate

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             acc_q, acc_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_y;
  logic             unused_subtract;

  assign unused_subtract = subtract;

  // One evaluator is shared by every slice; idx_q steers which operand bits
  // it sees this cycle.
  assign slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .op (op_q),
    .a  (slice_a),
    .b  (slice_b),
    .y  (slice_y)
  );

  // State and datapath registers; reset wipes any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath. done and zero are registered together on the
  // edge leaving S_DONE so they become visible in the same cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          zero_d   = 1'b0;
          acc_d    = 1'b1;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[int'(idx_q) * CHUNK +: CHUNK] = slice_y;
        acc_d = acc_q & (slice_y == '0);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        zero_d  = acc_q;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carryout = 1'b0;
  assign overflow = 1'b0;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: directed scenarios plus random
// operations compared against a whole-word reference model.
module tb_seq_logic_unit;

  logic        clk;
  logic        rst_n;

  // 32/8 instance
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, carryout, overflow;
  logic [31:0] result;

  // 32/32 instance
  logic        w_start;
  logic [2:0]  w_op;
  logic [31:0] w_a, w_b;
  logic        w_busy, w_done, w_zero, w_carryout, w_overflow;
  logic [31:0] w_result;

  int checks = 0;
  int passed = 0;

  seq_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .subtract(1'b0), .busy(busy), .done(done), .result(result),
    .zero(zero), .carryout(carryout), .overflow(overflow)
  );

  seq_logic_unit #(.WIDTH(32), .CHUNK(32)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .op(w_op), .a(w_a), .b(w_b),
    .subtract(1'b1), .busy(w_busy), .done(w_done), .result(w_result),
    .zero(w_zero), .carryout(w_carryout), .overflow(w_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: the result of an op does not depend on how many
  // bits are processed per cycle.
  function automatic logic [31:0] refOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return ~(x & y);
      3'd2: return x | y;
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Present a request to the 32/8 instance for one accepting edge, then
  // scramble the live inputs so only the captured copies can matter.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
  endtask

  // Wait (bounded) for done, counting edges since the accepting edge, then
  // check the completed outputs and that done lasts one cycle.
  task automatic checkOutput(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
    checkEq({tag, "_done"}, 32'(done), 32'd1);
    checkEq({tag, "_latency"}, 32'(n), 32'(exp_lat));
    checkEq({tag, "_result"}, result, exp_res);
    checkEq({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'h0));
    checkEq({tag, "_carry_ovf"}, {30'h0, carryout, overflow}, 32'h0);
    @(posedge clk);
    #1;
    checkEq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          n;

    rst_n = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0;
    w_start = 1'b0; w_op = '0; w_a = '0; w_b = '0;
    #12;
    checkEq("reset_busy", 32'(busy), 32'd0);
    checkEq("reset_done", 32'(done), 32'd0);
    checkEq("reset_result", result, 32'h0);
    checkEq("reset_zero", 32'(zero), 32'd0);
    checkEq("reset_carry_ovf", {30'h0, carryout, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed ops");
    applyStimulus(3'd0, 32'hF0F01234, 32'hFF00FFFF);
    checkEq("and_busy", 32'(busy), 32'd1);
    checkEq("and_partial_zero", 32'(zero), 32'd0);
    checkOutput("and", 32'hF0001234, 5);
    applyStimulus(3'd4, 32'hDEADBEEF, 32'hDEADBEEF);
    checkOutput("xor_same", 32'h00000000, 5);
    applyStimulus(3'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    checkOutput("xnor_same", 32'hFFFFFFFF, 5);
    applyStimulus(3'd3, 32'h0, 32'h0);
    checkOutput("nor_zero", 32'hFFFFFFFF, 5);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("nand_ones", 32'h00000000, 5);
    applyStimulus(3'd2, 32'h0000FF00, 32'h00FF0000);
    checkOutput("or", 32'h00FFFF00, 5);
    checkEq("or_hold_result", result, 32'h00FFFF00);

    $display("[TB] start held across busy");
    @(negedge clk);
    op = 3'd0; a = 32'h0000000F; b = 32'h000000FF; start = 1'b1;
    @(posedge clk);
    #1;
    op = 3'd2; a = 32'hF0000000; b = 32'h0;
    checkOutput("held_first", 32'h0000000F, 5);
    start = 1'b0;
    checkOutput("held_second", 32'hF0000000, 5);

    $display("[TB] reset mid-run");
    applyStimulus(3'd0, 32'hFFFFFFFF, 32'h12345678);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkEq("rst_busy", 32'(busy), 32'd0);
    checkEq("rst_done", 32'(done), 32'd0);
    checkEq("rst_result", result, 32'h0);
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    checkEq("rst_no_done", 32'(n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'd4, 32'h1, 32'h3);
    checkOutput("post_rst_xor", 32'h2, 5);

    $display("[TB] CHUNK=WIDTH instance, illegal op");
    @(negedge clk);
    w_op = 3'd6; w_a = 32'hFFFFFFFF; w_b = 32'hFFFFFFFF; w_start = 1'b1;
    @(posedge clk);
    #1;
    w_start = 1'b0; w_op = 3'd2;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!w_done && n < 20);
    checkEq("wide_done", 32'(w_done), 32'd1);
    checkEq("wide_latency", 32'(n), 32'd2);
    checkEq("wide_result", w_result, 32'h0);
    checkEq("wide_zero", 32'(w_zero), 32'd1);
    checkEq("wide_carry_ovf", {30'h0, w_carryout, w_overflow}, 32'h0);

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 8 == 0) r_b = r_a;
      applyStimulus(r_op, r_a, r_b);
      checkOutput("rand", refOp(r_op, r_a, r_b), 5);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
